// File: rtl/playback_pkg.sv
// Shared types and constants for the playback sequencer: state encoding,
// latency counter width and default geometry.
package playback_pkg;

  localparam int CNT_W       = 4;
  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_ROM_LAT = 2;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_SYNC_LOAD = 4'd1,
    ST_LOAD      = 4'd2,
    ST_WAIT      = 4'd3,
    ST_CAPTURE   = 4'd4,
    ST_SYNC_INC  = 4'd5,
    ST_INC       = 4'd6
  } state_t;

endpackage

// File: rtl/playback_lat_cnt.sv
// ROM latency down-counter: loads ROM_LAT on entry to WAIT and flags expiry
// at zero, so WAIT spans ROM_LAT+1 cycles.
module playback_lat_cnt
  import playback_pkg::*;
#(
  parameter int ROM_LAT = DEF_ROM_LAT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic expired
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(ROM_LAT);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/playback_seq.sv
// Playback sequencer: steps a ROM address once per sample period from start to
// end (wrapping), strobes sample capture after the ROM latency, pulses done.
// Optional PLAYBACK_LOOP_EN adds loop_en to restart at start_q on an end match.
module playback_seq
  import playback_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int ROM_LAT = DEF_ROM_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic              period_expired,
  input  logic              abort,
`ifdef PLAYBACK_LOOP_EN
  input  logic              loop_en,
`endif
  output logic              busy,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              sample_capture,
  output logic              done
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] start_q, end_q;
  logic              lat_load, lat_expired, end_match, done_nxt, loop_sel;

`ifdef PLAYBACK_LOOP_EN
  assign loop_sel = loop_en;
`else
  assign loop_sel = 1'b0;
`endif

  assign end_match = (rom_addr == end_q);

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    lat_load  = 1'b0;
    // Abort wins over every other transition once a playback is underway.
    if ((state != ST_IDLE) && abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:      if (start) state_nxt = ST_SYNC_LOAD;
        ST_SYNC_LOAD: if (period_expired) state_nxt = ST_LOAD;
        ST_LOAD: begin
          state_nxt = ST_WAIT;
          lat_load  = 1'b1;
        end
        ST_WAIT:      if (lat_expired) state_nxt = ST_CAPTURE;
        ST_CAPTURE: begin
          if (!end_match) begin
            state_nxt = ST_SYNC_INC;
          end else if (loop_sel) begin
            state_nxt = ST_SYNC_LOAD;
          end else begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end
        end
        ST_SYNC_INC:  if (period_expired) state_nxt = ST_INC;
        ST_INC: begin
          state_nxt = ST_WAIT;
          lat_load  = 1'b1;
        end
        default:      state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      done     <= 1'b0;
      start_q  <= '0;
      end_q    <= '0;
      rom_addr <= '0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
      if ((state == ST_IDLE) && start) begin
        start_q <= start_addr;
        end_q   <= end_addr;
      end
      // Pointer only moves when the FSM really advances into WAIT.
      if ((state == ST_LOAD) && !abort) begin
        rom_addr <= start_q;
      end else if ((state == ST_INC) && !abort) begin
        rom_addr <= rom_addr + ADDR_W'(1);
      end
    end
  end

  assign busy           = (state != ST_IDLE);
  assign sample_capture = (state == ST_CAPTURE);

  playback_lat_cnt #(
    .ROM_LAT (ROM_LAT)
  ) u_lat_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (lat_load),
    .dec     (state == ST_WAIT),
    .expired (lat_expired)
  );

endmodule

// File: tb/tb_playback_seq.sv
// Bench for playback_seq: table-driven playbacks, reset/abort/loop sequences and
// randomized playbacks checked against a capture-schedule model.
module tb_playback_seq;

  localparam int ROM_LAT = 2;
  localparam int PER     = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] start_addr = '0;
  logic [15:0] end_addr = '0;
  logic        period_expired = 1'b0;
  logic        abort = 1'b0;
`ifdef PLAYBACK_LOOP_EN
  logic        loop_en = 1'b0;
`endif
  logic        busy, sample_capture, done;
  logic [15:0] rom_addr;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int cap_cyc[$];
  logic [15:0] cap_addr[$];
  int done_cyc[$];

  playback_seq #(.ADDR_W(16), .ROM_LAT(ROM_LAT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .start_addr     (start_addr),
    .end_addr       (end_addr),
    .period_expired (period_expired),
    .abort          (abort),
`ifdef PLAYBACK_LOOP_EN
    .loop_en        (loop_en),
`endif
    .busy           (busy),
    .rom_addr       (rom_addr),
    .sample_capture (sample_capture),
    .done           (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Timer tick lands on every edge whose index is a multiple of PER.
  initial forever begin
    @(negedge clk);
    period_expired = (((cyc + 1) % PER) == 0);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (sample_capture) begin
        cap_cyc.push_back(cyc);
        cap_addr.push_back(rom_addr);
      end
      if (done) done_cyc.push_back(cyc);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_q();
    cap_cyc.delete();
    cap_addr.delete();
    done_cyc.delete();
  endtask

  function automatic int first_tick(input int n);
    return (n / PER + 1) * PER;
  endfunction

  // Model: captures at s, s+1, ... e (mod 2^16), first one ROM_LAT+2 cycles
  // after the first tick following acceptance, then one per period, done +1.
  task automatic run_play(input logic [15:0] s, input logic [15:0] e,
                          input int n, input bit immediate);
    int nacc, t0;
    bit got;
    logic [15:0] a;
    if (!immediate) step();
    clear_q();
    start = 1'b1; start_addr = s; end_addr = e;
    nacc = cyc + 1;
    step();
    start = 1'b0; start_addr = 16'($urandom); end_addr = 16'($urandom);
    t0 = first_tick(nacc) + ROM_LAT + 2;
    got = 1'b0;
    for (int k = 0; k < PER * n + 40 && !got; k++) begin
      step();
      if (done_cyc.size() > 0) got = 1'b1;
    end
    chk("done_seen", 32'(got), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("cap_count", cap_cyc.size(), n);
    for (int i = 0; i < n && i < cap_cyc.size(); i++) begin
      a = s + 16'(i);
      chk("cap_addr", 32'(cap_addr[i]), 32'(a));
      chk("cap_cyc", cap_cyc[i], t0 + PER * i);
    end
    if (got) chk("done_cyc", done_cyc[0], t0 + PER * (n - 1) + 1);
  endtask

  typedef struct {
    logic [15:0] s;
    logic [15:0] e;
    int          n;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int nacc, m, nrand;
    bit got;
    logic [15:0] rs, rl;

    vecs[0] = '{16'h0010, 16'h0012, 3};
    vecs[1] = '{16'h0005, 16'h0005, 1};
    vecs[2] = '{16'hFFFE, 16'h0001, 4};
    vecs[3] = '{16'h7FFF, 16'h8000, 2};

    // Reset state
    repeat (3) step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_cap", 32'(sample_capture), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    repeat (2) step();

    // Reset asserted mid-WAIT
    clear_q();
    start = 1'b1; start_addr = 16'h0100; end_addr = 16'h0105;
    nacc = cyc + 1;
    step();
    start = 1'b0;
    m = first_tick(nacc);
    while (cyc < m + 2) step();
    chk("wait_busy", 32'(busy), 32'd1);
    chk("wait_addr", 32'(rom_addr), 32'h0100);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_addr", 32'(rom_addr), 32'd0);
    chk("arst_cap", 32'(sample_capture), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (20) step();
    chk("arst_no_cap", cap_cyc.size(), 0);
    chk("arst_no_done", done_cyc.size(), 0);
    chk("arst_idle", 32'(busy), 32'd0);

    // Table-driven playbacks
    for (int i = 0; i < 4; i++) run_play(vecs[i].s, vecs[i].e, vecs[i].n, 1'b0);
    // Start accepted in the same cycle done is high
    run_play(16'h0033, 16'h0034, 2, 1'b1);

    // Abort during second WAIT; start while busy ignored
    step();
    clear_q();
    start = 1'b1; start_addr = 16'h0040; end_addr = 16'h0048;
    nacc = cyc + 1;
    step();
    start = 1'b0;
    m = first_tick(nacc);
    while (cyc < m + 1) step();
    start = 1'b1; start_addr = 16'h0999; end_addr = 16'h0999;
    step();
    start = 1'b0;
    while (cyc < m + 9) step();
    chk("abort_pre_busy", 32'(busy), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (30) step();
    chk("abort_caps", cap_cyc.size(), 1);
    if (cap_addr.size() > 0) chk("abort_addr", 32'(cap_addr[0]), 32'h0040);
    chk("abort_no_done", done_cyc.size(), 0);
    chk("abort_idle", 32'(busy), 32'd0);

`ifdef PLAYBACK_LOOP_EN
    // Looping playback, loop_en dropped before the third 0x21 capture
    loop_en = 1'b1;
    step();
    clear_q();
    start = 1'b1; start_addr = 16'h0020; end_addr = 16'h0021;
    nacc = cyc + 1;
    step();
    start = 1'b0;
    m = first_tick(nacc) + ROM_LAT + 2;
    while (cyc < m + 34) step();
    chk("loop_no_done", done_cyc.size(), 0);
    chk("loop_busy", 32'(busy), 32'd1);
    loop_en = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      step();
      if (done_cyc.size() > 0) got = 1'b1;
    end
    chk("loop_done_seen", 32'(got), 32'd1);
    chk("loop_caps", cap_cyc.size(), 6);
    for (int i = 0; i < 6 && i < cap_cyc.size(); i++) begin
      chk("loop_addr", 32'(cap_addr[i]), (i % 2 == 0) ? 32'h20 : 32'h21);
      chk("loop_cyc", cap_cyc[i], m + PER * i);
    end
    if (got) chk("loop_done_cyc", done_cyc[0], m + PER * 5 + 1);
`endif

    // Randomized playbacks, biased toward the wrap point
    for (int r = 0; r < 8; r++) begin
      rs = ($urandom_range(0, 2) == 0) ? 16'hFFFF - 16'($urandom_range(0, 3))
                                       : 16'($urandom);
      rl = 16'($urandom_range(0, 5));
      nrand = int'(rl) + 1;
      repeat ($urandom_range(0, 9)) step();
      run_play(rs, rs + rl, nrand, 1'($urandom_range(0, 1)));
    end

    // Quiet afterwards
    clear_q();
    repeat (24) step();
    chk("quiet_caps", cap_cyc.size(), 0);
    chk("quiet_done", done_cyc.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/playback_seq.md
# playback_seq

Parametrised playback sequencer for the speech-synthesis datapath. Accepts a start/end address pair for one utterance, steps an internal ROM address pointer once per sample period, waits a configurable ROM latency, and strobes the capture of each sample into the output register. It sits between the command/address front end and the sample ROM/DAC path. It absorbs the separate address-pointer block and adds abort, address wrap-around and a completion pulse.

## Interface
Parameters:
- ADDR_W, 16, width of ROM address and start/end addresses.
- ROM_LAT, 2, ROM read latency in cycles (legal 0..14).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request playback; sampled only in IDLE.
- start_addr  in  ADDR_W  first sample address; latched with start.
- end_addr  in  ADDR_W  last sample address; latched with start.
- period_expired  in  1  one-cycle sample-rate tick from the period timer.
- abort  in  1  terminate current playback.
- busy  out  1  high in every state except IDLE.
- rom_addr  out  ADDR_W  registered ROM address.
- sample_capture  out  1  load strobe for the sample register.
- done  out  1  one-cycle pulse on normal completion.

## Operation
- Reset values: busy=0, sample_capture=0, done=0, rom_addr=0, state=IDLE, latched addresses=0.
- States:
  - IDLE: start=1 latches start_addr/end_addr and moves to SYNC_LOAD.
  - SYNC_LOAD: moves to LOAD on period_expired; otherwise holds.
  - LOAD: rom_addr <= start_q; next state is WAIT.
  - WAIT: lasts ROM_LAT+1 cycles (1 address-register stage plus ROM latency), counted by a down-counter; then moves to CAPTURE.
  - CAPTURE: if rom_addr == end_q, go to IDLE and set done for one cycle; otherwise go to SYNC_INC.
  - SYNC_INC: moves to INC on period_expired; otherwise holds.
  - INC: rom_addr <= rom_addr + 1, modulo 2^ADDR_W; next state is WAIT.
- Outputs busy and sample_capture are Moore-decoded from state. sample_capture=1 only in CAPTURE.
- Address arithmetic is unsigned and wraps at 2^ADDR_W. If end_q < start_q, playback runs through the wrap to end_q.
- start=end produces exactly one capture.
- period_expired outside the SYNC states is ignored and not remembered.
- start while busy is ignored. Input addresses may change freely after acceptance.
- abort=1 in any non-IDLE state forces IDLE on the next edge, with no done.
  - abort has priority over period_expired, the end match and loop.
  - sample_capture still shows for a CAPTURE cycle coinciding with abort.
- Asynchronous reset mid-operation returns to reset values immediately. No done is produced.

## Timing
- start accepted at edge N: SYNC_LOAD from N+1.
- period_expired seen in SYNC_LOAD at edge M:
  - LOAD in cycle M+1.
  - rom_addr valid from M+2.
  - CAPTURE in cycle M+2+ROM_LAT+1.
- Sample-to-sample spacing equals the timer period, provided the period exceeds ROM_LAT+4 cycles. Otherwise ticks landing outside SYNC_INC are dropped.
- done is high in the first IDLE cycle after the final CAPTURE; busy is already 0 in that cycle.
- A new start is accepted in the same cycle that done is high.

## Configuration
- PLAYBACK_LOOP_EN defined:
  - Adds input port loop_en (1 bit).
  - In CAPTURE with an end match and loop_en=1, the next state is SYNC_LOAD (reloads start_q), with no done and busy held high.
  - loop_en is sampled only in CAPTURE.
- PLAYBACK_LOOP_EN undefined: the port is absent and an end match always completes.

## Structure
- Shared package playback_pkg:
  - State enum and encoding (4-bit).
  - WAIT counter width constant (4 bits).
  - Default ADDR_W/ROM_LAT localparams.
- One natural sub-module: playback_lat_cnt.
  - Loads ROM_LAT on entry to WAIT and asserts its expiry flag at zero.
- The address pointer stays in the top module.

## Test plan
Default parameters; period_expired pulses every 8 cycles unless noted.
- Reset mid-WAIT: assert rst_n=0 -> busy=0, rom_addr=0, sample_capture=0 immediately; no done; next start behaves normally.
- start_addr=0x0010, end_addr=0x0012 -> three sample_capture pulses with rom_addr 0x0010, 0x0011, 0x0012; pulses 8 cycles apart; single done after the third; first capture 4 cycles after LOAD.
- start_addr=end_addr=0x0005 -> exactly one capture at 0x0005, then done.
- Wrap: start_addr=0xFFFE, end_addr=0x0001 -> captures at 0xFFFE, 0xFFFF, 0x0000, 0x0001, then done.
- Abort: assert abort during the second WAIT -> busy=0 next cycle, no further capture, no done; start pulsed while busy earlier has no effect.
- PLAYBACK_LOOP_EN, loop_en=1, start_addr=0x0020, end_addr=0x0021 -> captures 0x20, 0x21, 0x20, 0x21... with no done. Drop loop_en before a 0x21 capture -> playback ends there and done pulses once.
